instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of fetch-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 SHALL have port Clock, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Imem_Req, output, 1, instruction-memory fetch request this cycle.
REQ-006 SHALL have port Imem_Addr, output, 64, fetch address; valid when Imem_Req=1.
REQ-007 SHALL have port Imem_Data, input, 32, instruction word; valid exactly one cycle after the request.
REQ-008 SHALL have port Redirect, input, 1, taken-branch pulse from the branch path (Branch AND Zero).
REQ-009 SHALL have port Redirect_Addr, input, 64, branch target (PC + sign-extended offset << 2).
REQ-010 SHALL have port Out_Valid, output, 1, queue head holds an instruction for the decoder.
REQ-011 SHALL have port Out_Ready, input, 1, decoder accepts the head this cycle.
REQ-012 SHALL have port Out_Instr, output, 32, head instruction word (bits [31:21] feed the opcode decoder).
REQ-013 SHALL have port Out_PC, output, 64, address of the head instruction.
REQ-014 SHALL have port Queue_Count, output, $clog2(DEPTH)+1, current number of occupied entries.

Function
REQ-015 SHALL implement FSM states IDLE (first cycle after reset release, no request) and RUN (fetching); IDLE->RUN unconditionally after one cycle; RUN stays in RUN.
REQ-016 SHALL in RUN assert Imem_Req when Queue_Count + inflight - pop < DEPTH, pop = Out_Valid AND Out_Ready, and Redirect=0.
REQ-017 SHALL drive Imem_Addr from the fetch PC and advance the PC by 4 on each issued request, with modulo-2^64 wrap-around.
REQ-018 SHALL, one cycle after a request, write {fetch address, Imem_Data} into the queue tail unless a Redirect occurred in the intervening edge.
REQ-019 SHALL drive Out_Valid = (Queue_Count != 0); Out_Instr/Out_PC combinationally from the head entry; zero when empty.
REQ-020 SHALL remove the head on pop; simultaneous push and pop SHALL leave Queue_Count unchanged.
REQ-021 SHALL never overflow: push only when credit was reserved at request time; hold Out_* stable while Out_Valid=1 and Out_Ready=0.
REQ-022 SHALL, on Redirect=1 at an edge, empty the queue, discard any in-flight response, and load the PC with {Redirect_Addr[63:2],2'b00}; the first request to the target is issued the following cycle.
REQ-023 SHALL give Redirect priority over push and pop in the same cycle; a pop coincident with Redirect still counts as consumed by the decoder.
REQ-024 SHALL have a Redirect-to-Out_Valid latency of 2 cycles (request, then queue write) and a reset-release-to-first-Out_Valid latency of 3 cycles.

Reset
REQ-025 SHALL, while Reset_n=0, hold FSM=IDLE, PC=RESET_PC, queue empty, inflight=0, Imem_Req=0, Out_Valid=0, Out_Instr=0, Out_PC=0, Queue_Count=0.
REQ-026 SHALL on reset assertion mid-operation drop all queued and in-flight instructions immediately, without waiting for a clock edge.

Configuration
REQ-027 SHALL, when macro IFQ_REDIRECT_COUNT_EN is defined, add output Redirect_Count (16 bits), reset to 0, incremented on every accepted Redirect, saturating at 16'hFFFF.
REQ-028 SHALL, when IFQ_REDIRECT_COUNT_EN is undefined, omit the Redirect_Count port and counter entirely; all other behaviour is identical.

Verification
REQ-029 SHALL cover reset release with RESET_PC=0 and Out_Ready=1: Imem_Addr sequence 0,4,8,..., first Out_Valid 3 cycles after release with Out_PC=0.
REQ-030 SHALL cover Out_Ready=0 held: exactly 4 requests (0,4,8,12) issued, Queue_Count=4, Imem_Req=0 thereafter, and head stable at PC=0.
REQ-031 SHALL cover full queue with Out_Ready=1 for one cycle: exactly one new request (16) issued, Queue_Count returns to 4, no entry lost or duplicated.
REQ-032 SHALL cover Redirect=1 with Redirect_Addr=0x103 and 3 entries queued: Queue_Count=0 next cycle, Imem_Addr=0x100, in-flight word dropped, Out_PC=0x100 2 cycles after Redirect.
REQ-033 SHALL cover PC=0xFFFF_FFFF_FFFF_FFFC: next request address 0, and Out_PC sequence ...FFFC then 0.
REQ-034 SHALL cover Reset_n pulsed low between edges with 2 entries queued: Out_Valid=0 and Queue_Count=0 asynchronously; with IFQ_REDIRECT_COUNT_EN, 3 redirects give Redirect_Count=3 and reset clears it to 0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: instruction fetch front end with a small credit-based queue.
// Requests are issued only when a queue slot is guaranteed for the response one
// cycle later, so the queue can never overflow. A Redirect flushes the queue,
// drops any in-flight response and restarts fetching at the branch target.
// Optional feature: define IFQ_REDIRECT_COUNT_EN to add a saturating 16-bit
// Redirect_Count output that counts accepted redirects.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  output logic                     Imem_Req,
  output logic [63:0]              Imem_Addr,
  input  logic [31:0]              Imem_Data,
  input  logic                     Redirect,
  input  logic [63:0]              Redirect_Addr,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [31:0]              Out_Instr,
  output logic [63:0]              Out_PC,
  output logic [$clog2(DEPTH):0]   Queue_Count
`ifdef IFQ_REDIRECT_COUNT_EN
  ,
  output logic [15:0]              Redirect_Count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [63:0]   inflight_addr_q, inflight_addr_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   entry_pc_q    [DEPTH];
  logic [63:0]   entry_pc_d    [DEPTH];
  logic [31:0]   entry_instr_q [DEPTH];
  logic [31:0]   entry_instr_d [DEPTH];

  logic          pop;
  logic          push;
  logic          fetch;
  logic [CW:0]   credit_used;

  // Redirect targets are word aligned, so the two low address bits are ignored.
  logic unused_redirect_low_bits;
  assign unused_redirect_low_bits = ^Redirect_Addr[1:0];

  // Head of the queue is presented directly to the decoder; zeroed when empty.
  assign Out_Valid   = (count_q != '0);
  assign Out_Instr   = Out_Valid ? entry_instr_q[head_q] : 32'h0;
  assign Out_PC      = Out_Valid ? entry_pc_q[head_q] : 64'h0;
  assign Queue_Count = count_q;
  assign Imem_Req    = fetch;
  assign Imem_Addr   = pc_q;

  // Handshakes and the credit check: a slot must remain for the new response
  // after counting occupied entries, the outstanding response and this pop.
  always_comb begin
    pop         = Out_Valid && Out_Ready;
    push        = inflight_q && !Redirect;
    credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    fetch       = (state_q == RUN) && !Redirect && (credit_used < DEPTH_W);
  end

  // Next-state logic: Redirect flushes everything and reloads the PC; otherwise
  // the queue pushes the returning word and pops the accepted head.
  always_comb begin
    state_d         = RUN;
    pc_d            = pc_q;
    inflight_d      = fetch;
    inflight_addr_d = pc_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    entry_pc_d      = entry_pc_q;
    entry_instr_d   = entry_instr_q;
    if (Redirect) begin
      pc_d    = {Redirect_Addr[63:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fetch) begin
        pc_d = pc_q + 64'd4;
      end
      if (push) begin
        entry_pc_d[tail_q]    = inflight_addr_q;
        entry_instr_d[tail_q] = Imem_Data;
        tail_d                = tail_q + PTR_ONE;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // State registers; reset drops queued and in-flight instructions immediately.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= 64'h0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_pc_q[i]    <= 64'h0;
        entry_instr_q[i] <= 32'h0;
      end
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      entry_pc_q      <= entry_pc_d;
      entry_instr_q   <= entry_instr_d;
    end
  end

`ifdef IFQ_REDIRECT_COUNT_EN
  logic [15:0] redirect_count_q, redirect_count_d;

  // Saturating count of accepted redirects.
  always_comb begin
    redirect_count_d = redirect_count_q;
    if (Redirect && (redirect_count_q != 16'hFFFF)) begin
      redirect_count_d = redirect_count_q + 16'd1;
    end
  end

  // Redirect counter register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      redirect_count_q <= 16'h0;
    end else begin
      redirect_count_q <= redirect_count_d;
    end
  end

  assign Redirect_Count = redirect_count_q;
`else
  // Without the counter option there is no redirect statistics logic.
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Testbench for instr_fetch_queue: a queue-level reference model predicts every
// output each cycle, and directed scenarios pin the model with literal values.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic                   Clock = 1'b0;
  logic                   Reset_n = 1'b0;
  logic                   Imem_Req;
  logic [63:0]            Imem_Addr;
  logic [31:0]            Imem_Data = 32'h0;
  logic                   Redirect = 1'b0;
  logic [63:0]            Redirect_Addr = 64'h0;
  logic                   Out_Valid;
  logic                   Out_Ready = 1'b0;
  logic [31:0]            Out_Instr;
  logic [63:0]            Out_PC;
  logic [$clog2(DEPTH):0] Queue_Count;
`ifdef IFQ_REDIRECT_COUNT_EN
  logic [15:0]            Redirect_Count;
`endif

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .Imem_Req      (Imem_Req),
    .Imem_Addr     (Imem_Addr),
    .Imem_Data     (Imem_Data),
    .Redirect      (Redirect),
    .Redirect_Addr (Redirect_Addr),
    .Out_Valid     (Out_Valid),
    .Out_Ready     (Out_Ready),
    .Out_Instr     (Out_Instr),
    .Out_PC        (Out_PC),
    .Queue_Count   (Queue_Count)
`ifdef IFQ_REDIRECT_COUNT_EN
    ,
    .Redirect_Count(Redirect_Count)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model state
  entry_t      m_q[$];
  logic        m_run;
  logic [63:0] m_pc;
  logic        m_pend_v;
  logic [63:0] m_pend_a;
  logic [15:0] m_rc;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  logic        obs_valid;
  logic        obs_req;
  logic [63:0] obs_pc;
  logic [63:0] obs_addr;
  logic [63:0] obs_count;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    return 32'hF800_0000 ^ a[31:0] ^ a[63:32];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_run    = 1'b0;
    m_pc     = 64'h0;
    m_pend_v = 1'b0;
    m_pend_a = 64'h0;
    m_rc     = 16'h0;
  endtask

  // One clock cycle: drive inputs mid-cycle, compare every output with the
  // model, then advance the model across the rising edge.
  task automatic applyStimulus(input logic ready, input logic redir, input logic [63:0] raddr);
    int   pop_i;
    logic exp_valid;
    logic exp_req;
    @(negedge Clock);
    Out_Ready     = ready;
    Redirect      = redir;
    Redirect_Addr = raddr;
    Imem_Data     = m_pend_v ? memWord(m_pend_a) : 32'hDEAD_BEEF;
    #1;
    exp_valid = (m_q.size() != 0);
    pop_i     = (exp_valid && ready) ? 1 : 0;
    exp_req   = m_run && !redir && ((m_q.size() + int'(m_pend_v) - pop_i) < DEPTH);
    checkOutput("out_valid", 64'(Out_Valid), 64'(exp_valid));
    checkOutput("queue_count", 64'(Queue_Count), 64'(m_q.size()));
    checkOutput("out_pc", Out_PC, exp_valid ? m_q[0].pc : 64'h0);
    checkOutput("out_instr", 64'(Out_Instr), exp_valid ? 64'(m_q[0].instr) : 64'h0);
    checkOutput("imem_req", 64'(Imem_Req), 64'(exp_req));
    if (exp_req) checkOutput("imem_addr", Imem_Addr, m_pc);
`ifdef IFQ_REDIRECT_COUNT_EN
    checkOutput("redirect_count", 64'(Redirect_Count), 64'(m_rc));
`endif
    obs_valid = Out_Valid;
    obs_req   = Imem_Req;
    obs_pc    = Out_PC;
    obs_addr  = Imem_Addr;
    obs_count = 64'(Queue_Count);
    if (Imem_Req) req_cnt++;
    @(posedge Clock);
    if (redir) begin
      m_q.delete();
      m_pend_v = 1'b0;
      m_pc     = {raddr[63:2], 2'b00};
      if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
    end else begin
      if (pop_i == 1) m_q.delete(0);
      if (m_pend_v) m_q.push_back('{pc: m_pend_a, instr: memWord(m_pend_a)});
      m_pend_v = exp_req;
      m_pend_a = m_pc;
      if (exp_req) m_pc = m_pc + 64'd4;
    end
    m_run = 1'b1;
  endtask

  // Hold reset for two edges, check reset values, release before the next negedge.
  task automatic doReset();
    #2;
    Reset_n = 1'b0;
    modelReset();
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset_imem_req", 64'(Imem_Req), 64'h0);
    checkOutput("reset_out_valid", 64'(Out_Valid), 64'h0);
    checkOutput("reset_out_pc", Out_PC, 64'h0);
    checkOutput("reset_out_instr", 64'(Out_Instr), 64'h0);
    checkOutput("reset_count", 64'(Queue_Count), 64'h0);
`ifdef IFQ_REDIRECT_COUNT_EN
    checkOutput("reset_redirect_count", 64'(Redirect_Count), 64'h0);
`endif
    #1;
    Reset_n = 1'b1;
  endtask

  initial begin
    // Reset release with the decoder always ready
    doReset();
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("idle_no_req", 64'(obs_req), 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("first_req_addr", obs_addr, 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("second_req_addr", obs_addr, 64'h4);
    checkOutput("not_yet_valid", 64'(obs_valid), 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("third_req_addr", obs_addr, 64'h8);
    checkOutput("first_valid", 64'(obs_valid), 64'h1);
    checkOutput("first_out_pc", obs_pc, 64'h0);
    repeat (4) applyStimulus(1'b1, 1'b0, 64'h0);

    // Decoder stalled: queue fills to DEPTH and fetching stops
    doReset();
    req_cnt = 0;
    repeat (8) applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("stall_req_total", 64'(req_cnt), 64'd4);
    checkOutput("stall_count", obs_count, 64'd4);
    checkOutput("stall_no_req", 64'(obs_req), 64'h0);
    checkOutput("stall_head_pc", obs_pc, 64'h0);

    // One pop from a full queue releases exactly one request
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("refill_req", 64'(obs_req), 64'h1);
    checkOutput("refill_addr", obs_addr, 64'h10);
    applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("refill_req_total", 64'(req_cnt), 64'd5);
    checkOutput("refill_count", obs_count, 64'd4);
    checkOutput("refill_head", obs_pc, 64'h4);
    checkOutput("refill_stall", 64'(obs_req), 64'h0);

    // Redirect with three entries queued and one response in flight
    applyStimulus(1'b1, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 64'h103);
    checkOutput("pre_redirect_count", obs_count, 64'd3);
    checkOutput("redirect_cycle_no_req", 64'(obs_req), 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("redir_flush", obs_count, 64'd0);
    checkOutput("redir_addr", obs_addr, 64'h100);
    applyStimulus(1'b0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 64'h0);
    checkOutput("redir_valid", 64'(obs_valid), 64'h1);
    checkOutput("redir_out_pc", obs_pc, 64'h100);
    repeat (3) applyStimulus(1'b1, 1'b0, 64'h0);

    // Redirect coincident with a pop, to the top of the address space
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("wrap_flush", obs_count, 64'd0);
    checkOutput("wrap_first_addr", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("wrap_next_addr", obs_addr, 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("wrap_pc_hi", obs_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("wrap_pc_lo", obs_pc, 64'h0);
    repeat (2) applyStimulus(1'b1, 1'b0, 64'h0);

    // Asynchronous reset pulse between edges with two entries queued
    doReset();
    repeat (4) applyStimulus(1'b0, 1'b0, 64'h0);
    #2;
    checkOutput("pulse_pre_count", 64'(Queue_Count), 64'd2);
    Reset_n = 1'b0;
    #1;
    checkOutput("pulse_out_valid", 64'(Out_Valid), 64'h0);
    checkOutput("pulse_count", 64'(Queue_Count), 64'h0);
    checkOutput("pulse_imem_req", 64'(Imem_Req), 64'h0);
    modelReset();
    #1;
    Reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("post_pulse_idle", 64'(obs_req), 64'h0);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("post_pulse_addr", obs_addr, 64'h0);
    repeat (4) applyStimulus(1'b1, 1'b0, 64'h0);

    // Three redirects, then reset
    applyStimulus(1'b1, 1'b1, 64'h200);
    applyStimulus(1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b1, 64'h300);
    applyStimulus(1'b1, 1'b1, 64'h400);
    applyStimulus(1'b1, 1'b0, 64'h0);
    checkOutput("three_redir_addr", obs_addr, 64'h400);
`ifdef IFQ_REDIRECT_COUNT_EN
    checkOutput("redirect_count_3", 64'(Redirect_Count), 64'd3);
`endif
    repeat (3) applyStimulus(1'b1, 1'b0, 64'h0);
    doReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
